// File: rtl/dso_key_menu_pkg.sv
// Shared DSO configuration definitions: menu encodings, reset values of all config outputs,
// and the v_scale lookup table with its reset index.
package dso_key_menu_pkg;

    typedef enum logic [2:0] {
        M_TLVL = 3'd0,
        M_DECI = 3'd1,
        M_EDGE = 3'd2,
        M_VSCL = 3'd3,
        M_LINE = 3'd4,
        M_FILT = 3'd5
    } menu_e;

    typedef struct packed {
        logic [7:0]  trig_level;
        logic [9:0]  deci_rate;
        logic        trig_edge;
        logic [2:0]  vscl_idx;
        logic        wave_run;
        logic        fft_en;
        logic        fir_en;
        logic [11:0] trig_line;
    } cfg_t;

    localparam logic [9:0] DECI_MIN      = 10'd1;
    localparam logic [9:0] DECI_MAX      = 10'd1023;
    localparam logic [2:0] VSCL_IDX_RST  = 3'd4;
    localparam logic [2:0] VSCL_IDX_MAX  = 3'd6;

    localparam cfg_t CFG_RST = '{
        trig_level: 8'd127,
        deci_rate:  10'd1,
        trig_edge:  1'b1,
        vscl_idx:   VSCL_IDX_RST,
        wave_run:   1'b1,
        fft_en:     1'b0,
        fir_en:     1'b1,
        trig_line:  12'd512
    };

    // Index 0..2 attenuate by 8/4/2, index 3..6 magnify by 1/2/4/8.
    function automatic logic [4:0] vscl_lut(input logic [2:0] idx);
        logic [4:0] v;
        case (idx)
            3'd0:    v = 5'b0_1000;
            3'd1:    v = 5'b0_0100;
            3'd2:    v = 5'b0_0010;
            3'd3:    v = 5'b1_0001;
            3'd4:    v = 5'b1_0010;
            3'd5:    v = 5'b1_0100;
            default: v = 5'b1_1000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/dso_key_menu_if.sv
// Key inputs and configuration outputs of the DSO menu controller.
// The DSO side (slave) consumes keys and drives the configuration.
interface dso_key_menu_if;
    logic [3:0]  key;
    logic [7:0]  trig_level;
    logic [9:0]  deci_rate;
    logic        trig_edge;
    logic [4:0]  v_scale;
    logic        wave_run;
    logic        fft_en;
    logic        fir_en;
    logic [11:0] trig_line;
    logic [2:0]  menu_sel;
    logic        cfg_upd;

    modport master (
        output key,
        input  trig_level, deci_rate, trig_edge, v_scale, wave_run,
        input  fft_en, fir_en, trig_line, menu_sel, cfg_upd
    );

    modport slave (
        input  key,
        output trig_level, deci_rate, trig_edge, v_scale, wave_run,
        output fft_en, fir_en, trig_line, menu_sel, cfg_upd
    );
endinterface

// File: rtl/dso_key_menu_debounce.sv
// Per-key debounce: 2-FF sync, saturating low-level counter, one-shot press event, optional auto-repeat.
// Latency: event 2 + CNT_MAX+1 cycles after the key goes low; no backpressure, events are pulses.
module key_debounce #(
    parameter logic [19:0] CNT_MAX    = 20'd999_999,
    parameter logic [24:0] REPEAT_DLY = 25'd24_999_999,
    parameter logic [24:0] REPEAT_PER = 25'd4_999_999,
    parameter bit          REPEAT_EN  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic evt
);

    logic        sync1_q, sync1_d, sync2_q, sync2_d;
    logic [19:0] cnt_q, cnt_d;
    logic        held_q, held_d;
    logic [24:0] rep_cnt_q, rep_cnt_d;
    logic        rep_phase_q, rep_phase_d;
    logic        low, full, press, rep_fire;

    always_comb begin
        sync1_d     = key_n;
        sync2_d     = sync1_q;
        low         = ~sync2_q;
        full        = (cnt_q == CNT_MAX);
        cnt_d       = low ? (full ? cnt_q : cnt_q + 20'd1) : 20'd0;
        held_d      = low && full;
        press       = low && full && !held_q;
        rep_fire    = 1'b0;
        rep_cnt_d   = 25'd0;
        rep_phase_d = 1'b0;
        // rep_cnt_q counts cycles since the last press/repeat; phase 0 waits the initial delay.
        if (press) begin
            rep_cnt_d = 25'd1;
        end else if (low && held_q) begin
            if (rep_cnt_q == (rep_phase_q ? REPEAT_PER : REPEAT_DLY)) begin
                rep_fire    = REPEAT_EN;
                rep_cnt_d   = 25'd1;
                rep_phase_d = 1'b1;
            end else begin
                rep_cnt_d   = rep_cnt_q + 25'd1;
                rep_phase_d = rep_phase_q;
            end
        end
        evt = press || rep_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            cnt_q       <= 20'd0;
            held_q      <= 1'b0;
            rep_cnt_q   <= 25'd0;
            rep_phase_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            held_q      <= held_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end

endmodule

// File: rtl/dso_key_menu.sv
// Key-driven menu controller editing the DSO config registers with saturation.
// Latency: config updates the cycle after a key event, cfg_upd one cycle later; keys have no backpressure.
module dso_key_menu
    import dso_key_menu_pkg::*;
#(
    parameter logic [19:0] CNT_MAX    = 20'd999_999,
    parameter logic [24:0] REPEAT_DLY = 25'd24_999_999,
    parameter logic [24:0] REPEAT_PER = 25'd4_999_999,
    parameter logic [7:0]  TL_STEP    = 8'd4,
    parameter logic [11:0] LINE_STEP  = 12'd8,
    parameter logic [11:0] LINE_MIN   = 12'd0,
    parameter logic [11:0] LINE_MAX   = 12'd1023
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    dso_key_menu_if.slave  bus
);

    logic [3:0] evt;

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_debounce #(
            .CNT_MAX    (CNT_MAX),
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_PER (REPEAT_PER),
            .REPEAT_EN  ((i == 1) || (i == 2))
        ) u_db (
            .clk   (sys_clk),
            .rst_n (sys_rst_n),
            .key_n (bus.key[i]),
            .evt   (evt[i])
        );
    end

    menu_e       menu_q, menu_d;
    cfg_t        cfg_q, cfg_d;
    logic        chg_q, chg_d, cfg_upd_q, cfg_upd_d;
    logic        inc, dec;
    logic [8:0]  tl_inc, tl_dec;
    logic [12:0] ln_inc, ln_floor;

    always_comb begin
        menu_d    = menu_q;
        cfg_d     = cfg_q;
        inc       = 1'b0;
        dec       = 1'b0;
        tl_inc    = {1'b0, cfg_q.trig_level} + {1'b0, TL_STEP};
        tl_dec    = {1'b0, cfg_q.trig_level} - {1'b0, TL_STEP};
        ln_inc    = {1'b0, cfg_q.trig_line} + {1'b0, LINE_STEP};
        ln_floor  = {1'b0, LINE_MIN} + {1'b0, LINE_STEP};

        // One event per cycle; lower-priority events in the same cycle are dropped.
        if (evt[3]) begin
            cfg_d.wave_run = ~cfg_q.wave_run;
        end else if (evt[0]) begin
            case (menu_q)
                M_TLVL:  menu_d = M_DECI;
                M_DECI:  menu_d = M_EDGE;
                M_EDGE:  menu_d = M_VSCL;
                M_VSCL:  menu_d = M_LINE;
                M_LINE:  menu_d = M_FILT;
                default: menu_d = M_TLVL;
            endcase
        end else if (evt[1]) begin
            inc = 1'b1;
        end else if (evt[2]) begin
            dec = 1'b1;
        end

        if (inc || dec) begin
            case (menu_q)
                M_TLVL: begin
                    if (inc) cfg_d.trig_level = tl_inc[8] ? 8'hFF : tl_inc[7:0];
                    else     cfg_d.trig_level = tl_dec[8] ? 8'h00 : tl_dec[7:0];
                end
                M_DECI: begin
                    if (inc && cfg_q.deci_rate != DECI_MAX) cfg_d.deci_rate = cfg_q.deci_rate + 10'd1;
                    if (dec && cfg_q.deci_rate != DECI_MIN) cfg_d.deci_rate = cfg_q.deci_rate - 10'd1;
                end
                M_EDGE: cfg_d.trig_edge = ~cfg_q.trig_edge;
                M_VSCL: begin
                    if (inc && cfg_q.vscl_idx < VSCL_IDX_MAX) cfg_d.vscl_idx = cfg_q.vscl_idx + 3'd1;
                    if (dec && cfg_q.vscl_idx != 3'd0)        cfg_d.vscl_idx = cfg_q.vscl_idx - 3'd1;
                end
                M_LINE: begin
                    if (inc) cfg_d.trig_line = (ln_inc > {1'b0, LINE_MAX}) ? LINE_MAX : ln_inc[11:0];
                    else     cfg_d.trig_line = ({1'b0, cfg_q.trig_line} < ln_floor) ? LINE_MIN
                                                : cfg_q.trig_line - LINE_STEP;
                end
                M_FILT: begin
                    // Walk order on inc: 01 -> 10 -> 00 -> 11 -> 01.
                    case ({cfg_q.fft_en, cfg_q.fir_en})
                        2'b01:   {cfg_d.fft_en, cfg_d.fir_en} = inc ? 2'b10 : 2'b11;
                        2'b10:   {cfg_d.fft_en, cfg_d.fir_en} = inc ? 2'b00 : 2'b01;
                        2'b00:   {cfg_d.fft_en, cfg_d.fir_en} = inc ? 2'b11 : 2'b10;
                        default: {cfg_d.fft_en, cfg_d.fir_en} = inc ? 2'b01 : 2'b00;
                    endcase
                end
                default: ;
            endcase
        end

        chg_d     = (cfg_d != cfg_q);
        cfg_upd_d = chg_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            menu_q    <= M_TLVL;
            cfg_q     <= CFG_RST;
            chg_q     <= 1'b0;
            cfg_upd_q <= 1'b0;
        end else begin
            menu_q    <= menu_d;
            cfg_q     <= cfg_d;
            chg_q     <= chg_d;
            cfg_upd_q <= cfg_upd_d;
        end
    end

    assign bus.trig_level = cfg_q.trig_level;
    assign bus.deci_rate  = cfg_q.deci_rate;
    assign bus.trig_edge  = cfg_q.trig_edge;
    assign bus.v_scale    = vscl_lut(cfg_q.vscl_idx);
    assign bus.wave_run   = cfg_q.wave_run;
    assign bus.fft_en     = cfg_q.fft_en;
    assign bus.fir_en     = cfg_q.fir_en;
    assign bus.trig_line  = cfg_q.trig_line;
    assign bus.menu_sel   = menu_q;
    assign bus.cfg_upd    = cfg_upd_q;

endmodule

// File: tb/tb_dso_key_menu.sv
// Self-checking bench for dso_key_menu: reset, event latency, a table of key presses, priority and reset-mid-hold.
module tb_dso_key_menu;

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    always #5 sys_clk = ~sys_clk;

    dso_key_menu_if bus ();

    dso_key_menu #(
        .CNT_MAX    (20'd15),
        .REPEAT_DLY (25'd100),
        .REPEAT_PER (25'd20),
        .TL_STEP    (8'd4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    typedef struct {
        int          kidx;
        int          hold;
        logic [38:0] snap;
        logic [2:0]  menu;
        int          upd;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   upd_cnt = 0;

    always @(negedge sys_clk) if (bus.cfg_upd === 1'b1) upd_cnt++;

    function automatic logic [38:0] mk(input logic [7:0] tl, input logic [9:0] dr, input logic eg,
                                       input logic [4:0] vs, input logic rn, input logic ff,
                                       input logic fr, input logic [11:0] ln);
        return {tl, dr, eg, vs, rn, ff, fr, ln};
    endfunction

    function automatic logic [38:0] snap();
        return {bus.trig_level, bus.deci_rate, bus.trig_edge, bus.v_scale, bus.wave_run,
                bus.fft_en, bus.fir_en, bus.trig_line};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic add(input int k, input int h, input logic [38:0] s, input logic [2:0] m, input int u);
        vec_t v;
        v.kidx = k; v.hold = h; v.snap = s; v.menu = m; v.upd = u;
        tbl.push_back(v);
    endtask

    localparam logic [38:0] RST_SNAP = {8'd127, 10'd1, 1'b1, 5'b1_0010, 1'b1, 1'b0, 1'b1, 12'd512};

    initial begin
        int u0;
        bus.key   = 4'hF;
        sys_rst_n = 1'b0;
        tick(3);
        check("reset_cfg", 64'(snap()), 64'(RST_SNAP));
        check("reset_menu", 64'(bus.menu_sel), 64'd0);
        check("reset_upd", 64'(bus.cfg_upd), 64'd0);
        sys_rst_n = 1'b1;
        tick(3);
        check("post_reset_cfg", 64'(snap()), 64'(RST_SNAP));

        // Exact event latency: 2 sync + 16 debounce cycles, then output, then cfg_upd.
        bus.key[1] = 1'b0;
        tick(17);
        check("lat_tl_before", 64'(bus.trig_level), 64'd127);
        tick(1);
        check("lat_tl_after", 64'(bus.trig_level), 64'd131);
        check("lat_upd_early", 64'(bus.cfg_upd), 64'd0);
        tick(1);
        check("lat_upd_pulse", 64'(bus.cfg_upd), 64'd1);
        tick(1);
        check("lat_upd_end", 64'(bus.cfg_upd), 64'd0);
        bus.key[1] = 1'b1;
        tick(10);

        sys_rst_n = 1'b0;
        tick(2);
        sys_rst_n = 1'b1;
        tick(2);

        add(1, 10,  mk(127, 1, 1, 5'b10010, 1, 0, 1, 512), 0, 0);
        add(1, 15,  mk(127, 1, 1, 5'b10010, 1, 0, 1, 512), 0, 0);
        add(1, 16,  mk(131, 1, 1, 5'b10010, 1, 0, 1, 512), 0, 1);
        add(2, 20,  mk(127, 1, 1, 5'b10010, 1, 0, 1, 512), 0, 1);
        add(3, 20,  mk(127, 1, 1, 5'b10010, 0, 0, 1, 512), 0, 1);
        add(3, 20,  mk(127, 1, 1, 5'b10010, 1, 0, 1, 512), 0, 1);
        add(0, 20,  mk(127, 1, 1, 5'b10010, 1, 0, 1, 512), 1, 0);
        add(2, 20,  mk(127, 1, 1, 5'b10010, 1, 0, 1, 512), 1, 0);
        add(1, 20,  mk(127, 2, 1, 5'b10010, 1, 0, 1, 512), 1, 1);
        add(1, 116, mk(127, 4, 1, 5'b10010, 1, 0, 1, 512), 1, 2);
        add(2, 136, mk(127, 1, 1, 5'b10010, 1, 0, 1, 512), 1, 3);
        add(2, 20,  mk(127, 1, 1, 5'b10010, 1, 0, 1, 512), 1, 0);
        add(0, 20,  mk(127, 1, 1, 5'b10010, 1, 0, 1, 512), 2, 0);
        add(1, 20,  mk(127, 1, 0, 5'b10010, 1, 0, 1, 512), 2, 1);
        add(2, 20,  mk(127, 1, 1, 5'b10010, 1, 0, 1, 512), 2, 1);
        add(0, 20,  mk(127, 1, 1, 5'b10010, 1, 0, 1, 512), 3, 0);
        add(1, 20,  mk(127, 1, 1, 5'b10100, 1, 0, 1, 512), 3, 1);
        add(1, 20,  mk(127, 1, 1, 5'b11000, 1, 0, 1, 512), 3, 1);
        add(1, 20,  mk(127, 1, 1, 5'b11000, 1, 0, 1, 512), 3, 0);
        add(2, 20,  mk(127, 1, 1, 5'b10100, 1, 0, 1, 512), 3, 1);
        add(0, 20,  mk(127, 1, 1, 5'b10100, 1, 0, 1, 512), 4, 0);
        add(2, 160, mk(127, 1, 1, 5'b10100, 1, 0, 1, 480), 4, 4);
        add(1, 20,  mk(127, 1, 1, 5'b10100, 1, 0, 1, 488), 4, 1);
        add(0, 20,  mk(127, 1, 1, 5'b10100, 1, 0, 1, 488), 5, 0);
        add(1, 20,  mk(127, 1, 1, 5'b10100, 1, 1, 0, 488), 5, 1);
        add(1, 20,  mk(127, 1, 1, 5'b10100, 1, 0, 0, 488), 5, 1);
        add(1, 20,  mk(127, 1, 1, 5'b10100, 1, 1, 1, 488), 5, 1);
        add(1, 20,  mk(127, 1, 1, 5'b10100, 1, 0, 1, 488), 5, 1);
        add(2, 20,  mk(127, 1, 1, 5'b10100, 1, 1, 1, 488), 5, 1);
        add(2, 20,  mk(127, 1, 1, 5'b10100, 1, 0, 0, 488), 5, 1);
        add(0, 20,  mk(127, 1, 1, 5'b10100, 1, 0, 0, 488), 0, 0);
        add(1, 700, mk(251, 1, 1, 5'b10100, 1, 0, 0, 488), 0, 31);
        add(1, 20,  mk(255, 1, 1, 5'b10100, 1, 0, 0, 488), 0, 1);
        add(1, 20,  mk(255, 1, 1, 5'b10100, 1, 0, 0, 488), 0, 0);

        foreach (tbl[i]) begin
            u0 = upd_cnt;
            bus.key[tbl[i].kidx] = 1'b0;
            tick(tbl[i].hold);
            bus.key[tbl[i].kidx] = 1'b1;
            tick(10);
            check($sformatf("vec%0d_cfg", i), 64'(snap()), 64'(tbl[i].snap));
            check($sformatf("vec%0d_menu", i), 64'(bus.menu_sel), 64'(tbl[i].menu));
            check($sformatf("vec%0d_upd", i), 64'(upd_cnt - u0), 64'(tbl[i].upd));
        end

        // Simultaneous run/stop and inc: run/stop wins, inc dropped.
        u0 = upd_cnt;
        bus.key = 4'b0101;
        tick(20);
        bus.key = 4'hF;
        tick(10);
        check("prio_run_tl", 64'(snap()), 64'(mk(255, 1, 1, 5'b10100, 0, 0, 0, 488)));
        check("prio_run_upd", 64'(upd_cnt - u0), 64'd1);

        // Simultaneous menu-next and inc: menu advances, value untouched.
        bus.key = 4'b1100;
        tick(20);
        bus.key = 4'hF;
        tick(10);
        check("prio_menu_cfg", 64'(snap()), 64'(mk(255, 1, 1, 5'b10100, 0, 0, 0, 488)));
        check("prio_menu_sel", 64'(bus.menu_sel), 64'd1);

        // Reset while inc is held: immediate return to reset values, then one fresh press.
        bus.key[1] = 1'b0;
        tick(50);
        check("hold_deci", 64'(bus.deci_rate), 64'd2);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_cfg", 64'(snap()), 64'(RST_SNAP));
        check("async_rst_menu", 64'(bus.menu_sel), 64'd0);
        tick(2);
        sys_rst_n = 1'b1;
        u0 = upd_cnt;
        tick(30);
        bus.key[1] = 1'b1;
        tick(10);
        check("rst_hold_cfg", 64'(snap()), 64'(mk(131, 1, 1, 5'b10010, 1, 0, 1, 512)));
        check("rst_hold_upd", 64'(upd_cnt - u0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
